icache_refill_ctrl: RTL and testbench

//  Miss/refill sequencer for the instruction cache. Watches CPU fetches and the cache hit flag.

---
 rtl/icache_refill_ctrl_if.sv | 24 ++
 rtl/icache_refill_ctrl.sv | 63 ++++++
 tb/tb_icache_refill_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/icache_refill_ctrl_if.sv
// icache_refill_ctrl_if: fetch, memory-bus and cache-fill signals of the icache refill controller.
interface icache_refill_ctrl_if #(parameter int ADDR_W = 32, parameter int WORD_W = 32, parameter int WORDS_PER_LINE = 4);
  logic cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic cache_hit;
  logic stall;
  logic mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic mem_ack;
  logic mem_valid;
  logic [WORD_W-1:0] mem_data;
  logic fill_we;
  logic [ADDR_W-1:0] fill_addr;
  logic [WORD_W*WORDS_PER_LINE-1:0] fill_line;
  logic [31:0] miss_count;
  modport master (
    input cpu_req, cpu_addr, cache_hit, mem_ack, mem_valid, mem_data,
    output stall, mem_req, mem_addr, fill_we, fill_addr, fill_line, miss_count
  );
  modport slave (
    output cpu_req, cpu_addr, cache_hit, mem_ack, mem_valid, mem_data,
    input stall, mem_req, mem_addr, fill_we, fill_addr, fill_line, miss_count
  );
endinterface

// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl: icache miss sequencer, requests a line, gathers its beats, writes it in one cycle.
// Define PERF_CNT_EN to build the miss counter; otherwise miss_count is tied to zero.
module icache_refill_ctrl #(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32,
  parameter int WORDS_PER_LINE = 4
) (
  input logic clk,
  input logic reset,
  icache_refill_ctrl_if.master bus
);
  localparam int LINE_W = WORD_W * WORDS_PER_LINE;
  localparam int OFF_W = $clog2(LINE_W / 8);
  localparam int CNT_W = $clog2(WORDS_PER_LINE);
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, FILL = 2'd2, WRITE = 2'd3;
  logic [1:0] state;
  logic [CNT_W-1:0] count;
  logic [LINE_W-1:0] line_buf;
  logic miss, last;
  assign miss = state == IDLE && bus.cpu_req && !bus.cache_hit;
  assign last = count == CNT_W'(WORDS_PER_LINE - 1);
  // The miss cycle itself must stall, so IDLE stall is combinational from the fetch inputs.
  assign bus.stall = state == IDLE ? miss : 1'b1;
  assign bus.mem_req = state == REQ;
  assign bus.fill_we = state == WRITE;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      line_buf <= '0;
      bus.mem_addr <= '0;
      bus.fill_addr <= '0;
      bus.fill_line <= '0;
    end else begin
      if (miss) begin
        state <= REQ;
        bus.mem_addr <= {bus.cpu_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
        bus.fill_addr <= {bus.cpu_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
      end
      if (state == REQ && bus.mem_ack) begin
        state <= FILL;
        count <= '0;
      end
      if (state == FILL && bus.mem_valid) begin
        line_buf[count*WORD_W +: WORD_W] <= bus.mem_data;
        count <= count + 1'b1;
        if (last) begin
          state <= WRITE;
          bus.fill_line <= {bus.mem_data, line_buf[LINE_W-WORD_W-1:0]};
        end
      end
      if (state == WRITE) state <= IDLE;
    end
  end
`ifdef PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) bus.miss_count <= '0;
    else if (miss) bus.miss_count <= bus.miss_count + 1'b1;
  end
`else
  assign bus.miss_count = '0;
`endif
endmodule

// File: tb/tb_icache_refill_ctrl.sv
// tb_icache_refill_ctrl: directed scenarios for the icache refill controller with hand-computed expectations.
module tb_icache_refill_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  icache_refill_ctrl_if bus ();
  icache_refill_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.cpu_req = 1'b0;
    bus.cpu_addr = '0;
    bus.cache_hit = 1'b0;
    bus.mem_ack = 1'b0;
    bus.mem_valid = 1'b0;
    bus.mem_data = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.cpu_addr = 32'h1234_5670 + i;
      #1;
      total++;
      if ({bus.stall, bus.mem_req, bus.fill_we, bus.mem_addr, bus.fill_addr, bus.fill_line, bus.miss_count} !== '0) begin
        bad++;
        $display("FAIL reset_idle cyc=%0d stall=%b mem_req=%b fill_we=%b mem_addr=%h fill_addr=%h fill_line=%h miss_count=%h want all 0",
                 i, bus.stall, bus.mem_req, bus.fill_we, bus.mem_addr, bus.fill_addr, bus.fill_line, bus.miss_count);
      end
      tick();
    end
  endtask

  task automatic test_hit();
    for (int i = 0; i < 5; i++) begin
      bus.cpu_req = 1'b1;
      bus.cache_hit = 1'b1;
      bus.cpu_addr = 32'h0000_0010;
      #1;
      total++;
      if ({bus.stall, bus.mem_req, bus.fill_we} !== 3'b000) begin
        bad++;
        $display("FAIL hit cyc=%0d stall/mem_req/fill_we=%b want 000", i, {bus.stall, bus.mem_req, bus.fill_we});
      end
      tick();
    end
    idle_inputs();
  endtask

  // One complete refill: ack after ack_dly extra REQ cycles, gap idle cycles between beats.
  task automatic test_miss(input string name, input logic [31:0] addr, input logic [31:0] line_addr,
                           input int ack_dly, input int gap, input logic [127:0] line);
    bus.cpu_req = 1'b1;
    bus.cache_hit = 1'b0;
    bus.cpu_addr = addr;
    #1;
    total++;
    if ({bus.stall, bus.mem_req, bus.fill_we} !== 3'b100) begin
      bad++;
      $display("FAIL %s miss_cycle stall/mem_req/fill_we=%b want 100", name, {bus.stall, bus.mem_req, bus.fill_we});
    end
    tick();
    bus.cpu_addr = 32'hFFFF_FFF0;
    for (int i = 0; i <= ack_dly; i++) begin
      bus.cpu_req = i[0];
      bus.mem_ack = i == ack_dly;
      #1;
      total++;
      if ({bus.stall, bus.mem_req, bus.fill_we} !== 3'b110 || bus.mem_addr !== line_addr) begin
        bad++;
        $display("FAIL %s req cyc=%0d stall/mem_req/fill_we=%b mem_addr=%h want 110 %h",
                 name, i, {bus.stall, bus.mem_req, bus.fill_we}, bus.mem_addr, line_addr);
      end
      tick();
    end
    bus.mem_ack = 1'b0;
    for (int b = 0; b < 4; b++) begin
      for (int g = 0; g < (b == 0 ? 0 : gap); g++) begin
        bus.mem_valid = 1'b0;
        bus.mem_ack = 1'b1;
        #1;
        total++;
        if ({bus.stall, bus.mem_req, bus.fill_we} !== 3'b100) begin
          bad++;
          $display("FAIL %s gap b=%0d stall/mem_req/fill_we=%b want 100", name, b, {bus.stall, bus.mem_req, bus.fill_we});
        end
        tick();
      end
      bus.mem_ack = 1'b0;
      bus.mem_valid = 1'b1;
      bus.mem_data = line[32*b +: 32];
      #1;
      total++;
      if ({bus.stall, bus.mem_req, bus.fill_we} !== 3'b100) begin
        bad++;
        $display("FAIL %s beat b=%0d stall/mem_req/fill_we=%b want 100", name, b, {bus.stall, bus.mem_req, bus.fill_we});
      end
      tick();
    end
    bus.mem_valid = 1'b0;
    bus.mem_data = '0;
    #1;
    total++;
    if ({bus.stall, bus.mem_req, bus.fill_we} !== 3'b101 || bus.fill_line !== line || bus.fill_addr !== line_addr) begin
      bad++;
      $display("FAIL %s write stall/mem_req/fill_we=%b fill_addr=%h fill_line=%h want 101 %h %h",
               name, {bus.stall, bus.mem_req, bus.fill_we}, bus.fill_addr, bus.fill_line, line_addr, line);
    end
    tick();
    bus.cpu_req = 1'b1;
    bus.cpu_addr = addr;
    bus.cache_hit = 1'b1;
    #1;
    total++;
    if ({bus.stall, bus.mem_req, bus.fill_we} !== 3'b000 || bus.fill_line !== line) begin
      bad++;
      $display("FAIL %s after_write stall/mem_req/fill_we=%b fill_line=%h want 000 %h",
               name, {bus.stall, bus.mem_req, bus.fill_we}, bus.fill_line, line);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_reset_mid_fill();
    bus.cpu_req = 1'b1;
    bus.cpu_addr = 32'h0000_0044;
    tick();
    bus.cpu_req = 1'b0;
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    bus.mem_valid = 1'b1;
    bus.mem_data = 32'hDEAD_0000;
    tick();
    bus.mem_data = 32'hDEAD_0001;
    tick();
    reset = 1'b1;
    bus.mem_valid = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    total++;
    if ({bus.stall, bus.mem_req, bus.fill_we} !== 3'b000 || bus.mem_addr !== '0 || bus.miss_count !== '0) begin
      bad++;
      $display("FAIL reset_mid_fill stall/mem_req/fill_we=%b mem_addr=%h miss_count=%0d want 000 0 0",
               {bus.stall, bus.mem_req, bus.fill_we}, bus.mem_addr, bus.miss_count);
    end
    for (int i = 0; i < 4; i++) begin
      bus.mem_valid = 1'b1;
      bus.mem_data = 32'hBAD0_0000 + i;
      #1;
      total++;
      if ({bus.stall, bus.mem_req, bus.fill_we} !== 3'b000) begin
        bad++;
        $display("FAIL stray_valid cyc=%0d stall/mem_req/fill_we=%b want 000", i, {bus.stall, bus.mem_req, bus.fill_we});
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_miss_count();
    logic [31:0] want;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    test_miss("cnt_m1", 32'h0000_0100, 32'h0000_0100, 0, 0, 128'h01010101_02020202_03030303_04040404);
    test_hit();
    test_miss("cnt_m2", 32'h0000_0208, 32'h0000_0200, 1, 1, 128'h05050505_06060606_07070707_08080808);
    test_hit();
    test_miss("cnt_m3", 32'h0000_030C, 32'h0000_0300, 0, 0, 128'h090a0b0c_0d0e0f10_11121314_15161718);
`ifdef PERF_CNT_EN
    want = 32'd3;
`else
    want = 32'd0;
`endif
    #1;
    total++;
    if (bus.miss_count !== want) begin
      bad++;
      $display("FAIL miss_count got=%0d want=%0d", bus.miss_count, want);
    end
  endtask

  initial begin
    test_reset();
    test_hit();
    test_miss("zero_wait", 32'h0000_0004, 32'h0000_0000, 0, 0, 128'hafaeadacabaaa9a8a7a6a5a4a3a2a1a0);
    test_miss("slow_mem", 32'h0000_002C, 32'h0000_0020, 3, 2, 128'hafaeadacabaaa9a8a7a6a5a4a3a2a1a0);
    test_reset_mid_fill();
    test_miss("fresh_after_reset", 32'h0000_0048, 32'h0000_0040, 0, 0, 128'h1f1e1d1c1b1a19181716151413121110);
    test_miss_count();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
